// File: rtl/rv32_mem_stage.sv
// rtl/rv32_mem_stage.sv - RV32 MEM stage: data bus handshake, byte lanes, load extension, MEM/WB register
// Optional feature macro: RV32_MEM_MISALIGN_TRAP_EN (misaligned access trap, adds misalign_o)
module rv32_mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] bshift_in,
  input  logic [31:0] pc_ret_in,
  input  logic [31:0] data_store_in,
  input  logic [1:0]  data_ctrl_in,
  input  logic [2:0]  rf_in,
  input  logic        pc_hlt_in,
  input  logic [4:0]  sel_rd1_in,
  input  logic [31:0] code_in,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [2:0]  wb_rf,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_code,
  output logic        wb_valid,
  output logic        pc_hlt_out,
  output logic        bus_err_o
`ifdef RV32_MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic {IDLE, WAIT_RSP} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  f3;
  logic [1:0]  a;
  logic        mem_sel;
  logic        is_store;
  logic        misalign;
  logic        mem_op;
  logic        retire;
  logic        timeout_hit;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] wb_sel;

  assign f3        = code_in[14:12];
  assign a         = alu_res_in[1:0];
  assign mem_sel   = data_ctrl_in[1] & ~pc_hlt_in;
  assign is_store  = ~data_ctrl_in[0];
  assign dmem_we   = is_store;
  assign dmem_addr = {alu_res_in[31:2], 2'b00};

`ifdef RV32_MEM_MISALIGN_TRAP_EN
  assign misalign = mem_sel & (((f3[1:0] == 2'b01) & a[0]) |
                               ((f3[1:0] == 2'b10) & (a != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Misaligned accesses never reach the bus; they retire as bubbles-with-trap.
  assign mem_op  = mem_sel & ~misalign;
  assign stall_o = ~retire;

  // Handshake decode: bus request, retire point and response timeout.
  always_comb begin
    dmem_req    = 1'b0;
    retire      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          retire = 1'b1;
        end else begin
          dmem_req = 1'b1;
          retire   = dmem_gnt & is_store;
        end
      end
      WAIT_RSP: begin
        if (dmem_rvalid) begin
          retire = 1'b1;
        end else if ((TIMEOUT_CYC != 0) && (cnt == TIMEOUT_CYC - 32'd1)) begin
          retire      = 1'b1;
          timeout_hit = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Store lane placement: enables from size/offset, data replicated across lanes.
  always_comb begin
    dmem_be    = 4'hF;
    dmem_wdata = data_store_in;
    case (f3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << a;
        dmem_wdata = {4{data_store_in[7:0]}};
      end
      2'b01: begin
        dmem_be    = a[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{data_store_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane extraction followed by sign/zero extension.
  always_comb begin
    case (a)
      2'b00:   rd_byte = dmem_rdata[7:0];
      2'b01:   rd_byte = dmem_rdata[15:8];
      2'b10:   rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (f3)
      3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_ext = {24'h0, rd_byte};
      3'b101:  load_ext = {16'h0, rd_half};
      default: load_ext = dmem_rdata;
    endcase
  end

  // Writeback source select; a timed-out load substitutes the error pattern.
  always_comb begin
    case (rf_in[2:1])
      2'b00:   wb_sel = alu_res_in;
      2'b01:   wb_sel = bshift_in;
      2'b10:   wb_sel = pc_ret_in;
      default: wb_sel = timeout_hit ? ERR_DATA : load_ext;
    endcase
  end

  // Access FSM and WAIT_RSP cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 32'd0;
          if (mem_op && dmem_gnt && !is_store) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (retire) begin
            state <= IDLE;
            cnt   <= 32'd0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // MEM/WB register: payload holds during bubbles, write enable cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data    <= 32'd0;
      wb_rf      <= 3'd0;
      wb_rd      <= 5'd0;
      wb_code    <= 32'd0;
      wb_valid   <= 1'b0;
      pc_hlt_out <= 1'b1;
      bus_err_o  <= 1'b0;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
    end else begin
      wb_valid   <= retire;
      pc_hlt_out <= pc_hlt_in;
      bus_err_o  <= timeout_hit;
`ifdef RV32_MEM_MISALIGN_TRAP_EN
      misalign_o <= retire & misalign;
`endif
      if (retire) begin
        wb_data <= wb_sel;
        wb_rf   <= {rf_in[2:1], rf_in[0] & ~misalign};
        wb_rd   <= sel_rd1_in;
        wb_code <= code_in;
      end else begin
        wb_rf[0] <= 1'b0;
      end
    end
  end

endmodule
